// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the motor PWM control blocks: FSM state encoding,
// default widths/rates and a counter-width helper.
package pwm_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RAMP  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DECEL = 3'd3,
    ST_DEAD  = 3'd4
  } state_t;

  localparam int DEF_DUTY_W     = 8;
  localparam int DEF_RAMP_DIV   = 16;
  localparam int DEF_DEAD_TICKS = 64;

  // A count of 1 still needs a 1-bit register.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_sync.sv
// Brings the divided clock into the system clock domain and emits one
// registered single-cycle TICK per rising edge of it.
module tick_sync (
  input  logic CLK_100MHz,
  input  logic RST_N,
  input  logic CLK_DIV_IN,
  output logic TICK
);

  // sync[1:0] is the two-flop synchronizer, sync[2] the delayed copy for edge detect.
  logic [2:0] sync;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, exactly like the real shift chain.
  always_ff @(posedge CLK_100MHz or negedge RST_N) begin
    if (!RST_N) begin
      sync <= '0;
      TICK <= 1'b0;
    end else begin
      sync <= {sync[1:0], CLK_DIV_IN};
      TICK <= sync[1] & ~sync[2];
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start / direction-change sequencer: slews DUTY toward the request and
// routes every reversal or stop through deceleration and bridge dead time.
module pwm_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int DUTY_W     = DEF_DUTY_W,
  parameter int RAMP_DIV   = DEF_RAMP_DIV,
  parameter int DEAD_TICKS = DEF_DEAD_TICKS
) (
  input  logic              CLK_100MHz,
  input  logic              RST_N,
  input  logic              CLK_DIV_IN,
  input  logic              EN,
  input  logic [DUTY_W-1:0] DUTY_SET,
  input  logic              DIR_SET,
  output logic [DUTY_W-1:0] DUTY,
  output logic              DIR,
  output logic              DRIVE_EN,
  output logic              BUSY,
  output logic [2:0]        STATE
);

  localparam int STEP_W = cnt_w(RAMP_DIV);
  localparam int DEAD_W = cnt_w(DEAD_TICKS);
  localparam logic [STEP_W-1:0] STEP_LAST    = STEP_W'(RAMP_DIV - 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST    = DEAD_W'(DEAD_TICKS - 1);
  localparam logic [STEP_W-1:0] STEP_RESTART = STEP_W'((RAMP_DIV > 1) ? 1 : 0);
  localparam logic [DEAD_W-1:0] DEAD_RESTART = DEAD_W'((DEAD_TICKS > 1) ? 1 : 0);
  localparam logic [DUTY_W-1:0] DUTY_MAX     = '1;

  state_t            state, state_nx;
  logic [STEP_W-1:0] step_cnt;
  logic [DEAD_W-1:0] dead_cnt;
  logic [DUTY_W-1:0] target;
  logic              tick, step, dead_done, dir_mismatch, tick_carry;

  tick_sync u_tick_sync (
    .CLK_100MHz (CLK_100MHz),
    .RST_N      (RST_N),
    .CLK_DIV_IN (CLK_DIV_IN),
    .TICK       (tick)
  );

  assign target       = EN ? DUTY_SET : '0;
  assign dir_mismatch = (DIR_SET != DIR);
  assign step         = tick && (step_cnt == STEP_LAST);
  assign dead_done    = tick && (state == ST_DEAD) && (dead_cnt == DEAD_LAST);
  // The tick that finishes dead time is consumed there; any other tick seen
  // on a state change is credited to the new state's counter.
  assign tick_carry   = tick && !dead_done;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (target != '0) state_nx = ST_RAMP;
      ST_RAMP: begin
        if (dir_mismatch)                       state_nx = ST_DECEL;
        else if (DUTY == target && target != '0) state_nx = ST_HOLD;
        else if (DUTY == '0 && target == '0)     state_nx = ST_DEAD;
      end
      ST_HOLD: begin
        if (dir_mismatch)        state_nx = ST_DECEL;
        else if (target != DUTY) state_nx = ST_RAMP;
      end
      ST_DECEL: begin
        if (DUTY == '0)         state_nx = ST_DEAD;
        else if (!dir_mismatch) state_nx = ST_RAMP;
      end
      ST_DEAD:  if (dead_done) state_nx = (target != '0) ? ST_RAMP : ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_100MHz or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      step_cnt <= '0;
      dead_cnt <= '0;
      DUTY     <= '0;
      DIR      <= 1'b0;
    end else begin
      state <= state_nx;

      if (state_nx != state) begin
        step_cnt <= tick_carry ? STEP_RESTART : '0;
        dead_cnt <= tick_carry ? DEAD_RESTART : '0;
      end else if (tick) begin
        step_cnt <= step ? '0 : step_cnt + 1'b1;
        if (state == ST_DEAD) dead_cnt <= dead_cnt + 1'b1;
      end

      // DUTY only moves while the state is stable; a transition edge never steps.
      if (state_nx == state && step) begin
        if (state == ST_RAMP) begin
          if (DUTY < target && DUTY != DUTY_MAX)  DUTY <= DUTY + 1'b1;
          else if (DUTY > target && DUTY != '0)   DUTY <= DUTY - 1'b1;
        end else if (state == ST_DECEL && DUTY != '0) begin
          DUTY <= DUTY - 1'b1;
        end
      end

      if (state == ST_IDLE || dead_done) DIR <= DIR_SET;
    end
  end

  assign DRIVE_EN = (state inside {ST_RAMP, ST_HOLD, ST_DECEL}) && (DUTY != '0);
  assign BUSY     = (DUTY != target) || dir_mismatch || (state == ST_DEAD);
  assign STATE    = state;

endmodule

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Soft-start / direction-change sequencer for the motor PWM system. It samples the 48.8 kHz divided clock from the clock divider and turns each rising edge into a one-cycle tick. It then slews the duty command presented to the PWM generator toward the requested value. Direction reversals go through a decelerate → dead-time → reverse sequence, so the H-bridge is never reversed while driven.

## Interface
- DUTY_W, 8: duty command width
- RAMP_DIV, 16: ticks per ±1 duty step (≥1)
- DEAD_TICKS, 64: ticks of zero drive before a direction change (≥1)

- CLK_100MHz  in  1  system clock; all logic on its rising edge
- RST_N  in  1  asynchronous, active-low reset
- CLK_DIV_IN  in  1  divided clock (48.8 kHz square wave), asynchronous to this block's logic
- EN  in  1  motor enable request
- DUTY_SET  in  DUTY_W  target duty
- DIR_SET  in  1  target direction
- DUTY  out  DUTY_W  current duty command to the PWM generator
- DIR  out  1  current bridge direction
- DRIVE_EN  out  1  bridge enable
- BUSY  out  1  current command differs from the request
- STATE  out  3  FSM state

## Operation
- Tick: CLK_DIV_IN passes through a 2-FF synchronizer and a rising-edge detect, giving a registered one-cycle TICK. All counting uses TICK only.
- Target: DUTY_SET when EN=1, else 0.
- Step counter: counts TICKs 0..RAMP_DIV-1. A step fires on the tick that wraps the counter. The counter clears on every state change.
- States: IDLE=0, RAMP=1, HOLD=2, DECEL=3, DEAD=4.
- IDLE: DUTY=0, DRIVE_EN=0.
  - DIR follows DIR_SET every cycle.
  - EN=1 with DUTY_SET≠0 → RAMP.
- RAMP: on each step, DUTY moves ±1 toward the target.
  - DUTY==target≠0 → HOLD, evaluated every cycle.
  - DUTY==0 with target 0 → DEAD.
  - DIR_SET≠DIR → DECEL; this takes priority over the other transitions.
- HOLD: DUTY held.
  - Target≠DUTY → RAMP.
  - DIR_SET≠DIR → DECEL; this takes priority.
- DECEL: on each step, DUTY decrements regardless of target.
  - DUTY==0 → DEAD.
  - DIR_SET==DIR again before DUTY reaches 0 → RAMP (abort); DIR is never toggled in this case.
- DEAD: DRIVE_EN=0 and DUTY=0.
  - Counts DEAD_TICKS ticks.
  - On completion, DIR←DIR_SET, then go to RAMP if target≠0, else IDLE.
  - IDLE is entered only through DEAD or reset, so every stop is followed by dead time.
- DRIVE_EN=1 iff state ∈ {RAMP, HOLD, DECEL} and DUTY≠0.
- BUSY = (DUTY≠target) | (DIR≠DIR_SET) | (state==DEAD).
- Arithmetic: DUTY saturates at 0 and 2^DUTY_W−1 and never wraps. Counters are sized by $clog2 of their parameter.

## Timing
- Reset (asynchronous, immediate, no clock needed): DUTY=0, DIR=0, DRIVE_EN=0, BUSY=0, STATE=IDLE. Synchronizer, tick and counters clear.
- Reset mid-operation drops drive on the same instant. After release, the block starts in IDLE; it does not resume the previous state.
- Tick latency: first CLK_100MHz edge sampling CLK_DIV_IN=1 is edge k. TICK is high for the cycle after edge k+2. The DUTY update is visible after edge k+3.
- Exactly one TICK per CLK_DIV_IN period.
- Full ramp 0→N takes N·RAMP_DIV ticks.
- State transitions take effect on the edge following the condition. DUTY and the state register update on the same edge.
- TICK arriving on the same cycle as a state change: the tick counts toward the new state's counter, which starts at 1.
- DUTY_SET may change at any time. It is sampled every cycle, and no handshake is required.

## Structure
- Shared package pwm_ctrl_pkg holds:
  - state encoding constants (IDLE..DEAD, 3 bits)
  - default DUTY_W, RAMP_DIV and DEAD_TICKS.
- Sub-module tick_sync (CLK_100MHz, RST_N, CLK_DIV_IN → TICK) contains the 2-FF synchronizer and edge detect. It is reused by the PWM generator.
- The top level contains the FSM, step counter, dead counter and DUTY/DIR registers.

## Test plan
Bench parameters: RAMP_DIV=2, DEAD_TICKS=4, with a CLK_DIV_IN period of 2048 CLK_100MHz cycles.
1. Assert RST_N=0 mid-stream with no clock running → DUTY=0, DIR=0, DRIVE_EN=0, STATE=0 immediately.
2. EN=1, DUTY_SET=10, DIR_SET=0 → DUTY increments every 2 ticks, reaches 10 after 20 ticks; STATE=HOLD, BUSY=0, DRIVE_EN=1.
3. From HOLD at 10, set DUTY_SET=4 → RAMP down, DUTY=4 after 12 ticks, then HOLD.
4. At DUTY=4, set DIR_SET=1 → DECEL reaches 0 after 8 ticks; DEAD lasts 4 ticks with DRIVE_EN=0; DIR becomes 1; RAMP back to 4 after 8 more ticks.
5. At DUTY=4, set DIR_SET=1, then restore DIR_SET=0 when DUTY=2 → STATE goes to RAMP, DEAD is never entered, DIR stays 0, DUTY returns to 4.
6. EN=0 from HOLD at 4 → ramp to 0 in 8 ticks, DEAD for 4 ticks, then IDLE. Then assert RST_N=0 during a subsequent RAMP and check all outputs clear asynchronously.
